instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 134 +++++++++++++
 tb/tb_instruction_fetch.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Three-phase instruction sequencer (FETCH/DECODE/EXECUTE) with program
// counter, instruction register and a return-address stack for call/ret.
module instruction_fetch #(
    parameter logic [7:0] ROM_MAX     = 8'h1A,
    parameter int         STACK_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset_s2,
    output logic [7:0]  rom_address,
    input  logic [23:0] rom_data,
    input  logic        stall,
    input  logic        jump_en,
    input  logic        call_en,
    input  logic        ret_en,
    input  logic [7:0]  jump_addr,
    output logic [7:0]  op_code,
    output logic [7:0]  op1,
    output logic [7:0]  op2,
    output logic        instr_valid,
    output logic [7:0]  pc,
    output logic        stack_overflow,
    output logic        stack_underflow
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam int STACK_SLOTS = 1 << SP_W;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0] SP_ZERO = {SP_W{1'b0}};
    localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);

    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_DECODE  = 2'd1;
    localparam logic [1:0] ST_EXECUTE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [7:0]      pc_q, pc_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic [23:0]     ir_q, ir_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;
    logic [7:0]      stack_q [0:STACK_SLOTS-1];
    logic [7:0]      stack_d [0:STACK_SLOTS-1];
    logic [7:0]      target_s;

    // Out-of-range branch targets restart the program at address zero.
    assign target_s = (jump_addr > ROM_MAX) ? 8'h00 : jump_addr;

    // Next-state, program counter, instruction register and stack update.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        ir_d    = ir_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        stack_d = stack_q;
        case (state_q)
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ir_d    = rom_data;
                pc_d    = (pc_q == ROM_MAX) ? 8'h00 : pc_q + 8'h01;
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (stall) begin
                    state_d = ST_EXECUTE;
                end else begin
                    state_d = ST_FETCH;
                    if (ret_en) begin
                        if (sp_q == SP_ZERO) begin
                            pc_d  = 8'h00;
                            udf_d = 1'b1;
                        end else begin
                            pc_d = stack_q[sp_q - SP_ONE];
                            sp_d = sp_q - SP_ONE;
                        end
                    end else if (call_en) begin
                        // pc already holds the incremented return address here.
                        if (sp_q == SP_FULL) begin
                            ovf_d = 1'b1;
                        end else begin
                            stack_d[sp_q] = pc_q;
                            sp_d          = sp_q + SP_ONE;
                            pc_d          = target_s;
                        end
                    end else if (jump_en) begin
                        pc_d = target_s;
                    end else begin
                        pc_d = pc_q;
                    end
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Control and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset_s2) begin
            state_q <= ST_FETCH;
            pc_q    <= 8'h00;
            sp_q    <= SP_ZERO;
            ir_q    <= 24'h000000;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            ir_q    <= ir_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Return-address storage; contents are don't-care after reset.
    always_ff @(posedge clock) begin
        stack_q <= stack_d;
    end

    assign rom_address     = pc_q;
    assign pc              = pc_q;
    assign op_code         = ir_q[23:16];
    assign op1             = ir_q[15:8];
    assign op2             = ir_q[7:0];
    assign instr_valid     = (state_q == ST_EXECUTE);
    assign stack_overflow  = ovf_q;
    assign stack_underflow = udf_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: synchronous ROM model, expected
// instruction/pc pushed to a scoreboard queue at fetch and popped at execute.
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset_s2;
    logic [7:0]  rom_address;
    logic [23:0] rom_data;
    logic        stall, jump_en, call_en, ret_en;
    logic [7:0]  jump_addr;
    logic [7:0]  op_code, op1, op2, pc;
    logic        instr_valid, stack_overflow, stack_underflow;

    logic [23:0] rom [0:255];
    logic [31:0] expq [$];
    logic [7:0]  exp_stack [$];
    logic [7:0]  exp_pc;
    logic        exp_of, exp_uf;
    int          total = 0;
    int          bad = 0;

    instruction_fetch dut (
        .clock(clock), .reset_s2(reset_s2), .rom_address(rom_address),
        .rom_data(rom_data), .stall(stall), .jump_en(jump_en),
        .call_en(call_en), .ret_en(ret_en), .jump_addr(jump_addr),
        .op_code(op_code), .op1(op1), .op2(op2), .instr_valid(instr_valid),
        .pc(pc), .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
    );

    always #10 clock = ~clock;

    always @(posedge clock) rom_data <= rom[rom_address];

    initial begin
        #500000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        exp_pc = 8'h00;
        exp_of = 1'b0;
        exp_uf = 1'b0;
        exp_stack.delete();
    endtask

    // Runs one instruction starting in FETCH; noise on controls outside EXECUTE.
    task automatic do_instr(input logic r, input logic c, input logic j,
                            input logic [7:0] ja, input int nstall);
        logic [31:0] e;
        logic [7:0]  tgt;
        chk("fetch_valid", {31'd0, instr_valid}, 32'd0);
        expq.push_back({rom[exp_pc], ((exp_pc == 8'h1A) ? 8'h00 : exp_pc + 8'h01)});
        exp_pc = (exp_pc == 8'h1A) ? 8'h00 : exp_pc + 8'h01;
        ret_en = 1'b1; call_en = 1'b1; jump_en = 1'b1; jump_addr = 8'h03;
        step();
        chk("decode_valid", {31'd0, instr_valid}, 32'd0);
        step();
        ret_en = r; call_en = c; jump_en = j; jump_addr = ja;
        stall = (nstall > 0);
        e = expq.pop_front();
        chk("exec_valid", {31'd0, instr_valid}, 32'd1);
        chk("exec_ir", {8'd0, op_code, op1, op2}, {8'd0, e[31:8]});
        chk("exec_pc", {24'd0, pc}, {24'd0, e[7:0]});
        for (int k = 0; k < nstall; k++) begin
            step();
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_ir", {8'd0, op_code, op1, op2}, {8'd0, e[31:8]});
            chk("stall_pc", {24'd0, pc}, {24'd0, e[7:0]});
        end
        stall = 1'b0;
        step();
        ret_en = 1'b0; call_en = 1'b0; jump_en = 1'b0;
        tgt = (ja > 8'h1A) ? 8'h00 : ja;
        if (r) begin
            if (exp_stack.size() == 0) begin
                exp_pc = 8'h00;
                exp_uf = 1'b1;
            end else begin
                exp_pc = exp_stack.pop_back();
            end
        end else if (c) begin
            if (exp_stack.size() == 8) begin
                exp_of = 1'b1;
            end else begin
                exp_stack.push_back(exp_pc);
                exp_pc = tgt;
            end
        end else if (j) begin
            exp_pc = tgt;
        end
        chk("after_valid", {31'd0, instr_valid}, 32'd0);
        chk("after_pc", {24'd0, pc}, {24'd0, exp_pc});
        chk("after_ovf", {31'd0, stack_overflow}, {31'd0, exp_of});
        chk("after_udf", {31'd0, stack_underflow}, {31'd0, exp_uf});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = i[7:0];
            rom[i] = {b ^ 8'h5A, b, ~b};
        end
        rom[0] = 24'h0A1B2C;
        reset_s2 = 1'b1; stall = 1'b0; jump_en = 1'b0; call_en = 1'b0;
        ret_en = 1'b0; jump_addr = 8'h00;
        repeat (3) step();
        chk("rst_pc", {24'd0, pc}, 32'd0);
        chk("rst_addr", {24'd0, rom_address}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_ir", {8'd0, op_code, op1, op2}, 32'd0);
        chk("rst_flags", {30'd0, stack_overflow, stack_underflow}, 32'd0);
        reset_s2 = 1'b0;
        model_reset();

        do_instr(1'b0, 1'b0, 1'b0, 8'h00, 0);
        chk("first_ir", {8'd0, op_code, op1, op2}, 32'h000A1B2C);
        chk("first_pc", {24'd0, pc}, 32'h01);

        while (exp_pc != 8'h1A) do_instr(1'b0, 1'b0, 1'b0, 8'h00, 0);
        do_instr(1'b0, 1'b0, 1'b0, 8'h00, 0);
        chk("wrap_pc", {24'd0, pc}, 32'h00);
        while (exp_pc != 8'h05) do_instr(1'b0, 1'b0, 1'b0, 8'h00, 0);

        do_instr(1'b0, 1'b1, 1'b0, 8'h0D, 0);
        chk("call_pc", {24'd0, pc}, 32'h0D);
        do_instr(1'b0, 1'b0, 1'b0, 8'h00, 0);
        do_instr(1'b1, 1'b0, 1'b0, 8'h00, 0);
        chk("ret_pc", {24'd0, pc}, 32'h06);

        do_instr(1'b0, 1'b0, 1'b1, 8'h40, 0);
        chk("jump_oor_pc", {24'd0, pc}, 32'h00);
        do_instr(1'b0, 1'b0, 1'b1, 8'h12, 0);
        chk("jump_pc", {24'd0, pc}, 32'h12);

        do_instr(1'b0, 1'b1, 1'b0, 8'h10, 0);
        do_instr(1'b1, 1'b1, 1'b1, 8'h15, 4);
        chk("prio_pc", {24'd0, pc}, 32'h13);

        do_instr(1'b1, 1'b0, 1'b0, 8'h00, 0);
        chk("udf_pc", {24'd0, pc}, 32'h00);
        chk("udf_flag", {31'd0, stack_underflow}, 32'd1);

        for (int i = 0; i < 9; i++)
            do_instr(1'b0, 1'b1, 1'b0, (i == 2) ? 8'h30 : 8'h08, 0);
        chk("ovf_pc", {24'd0, pc}, 32'h09);
        chk("ovf_flag", {31'd0, stack_overflow}, 32'd1);

        reset_s2 = 1'b1;
        step();
        reset_s2 = 1'b0;
        model_reset();
        chk("rst2_flags", {30'd0, stack_overflow, stack_underflow}, 32'd0);
        repeat (3) do_instr(1'b0, 1'b1, 1'b0, 8'h04, 0);
        chk("sp_three", {28'd0, dut.sp_q}, 32'd3);

        step();
        step();
        stall = 1'b1; ret_en = 1'b1; call_en = 1'b1; jump_en = 1'b1;
        step();
        step();
        chk("stalled_valid", {31'd0, instr_valid}, 32'd1);
        reset_s2 = 1'b1;
        step();
        reset_s2 = 1'b0; stall = 1'b0; ret_en = 1'b0; call_en = 1'b0; jump_en = 1'b0;
        model_reset();
        chk("srst_valid", {31'd0, instr_valid}, 32'd0);
        chk("srst_pc", {24'd0, pc}, 32'h00);
        chk("srst_sp", {28'd0, dut.sp_q}, 32'd0);
        chk("srst_flags", {30'd0, stack_overflow, stack_underflow}, 32'd0);
        chk("srst_ir", {8'd0, op_code, op1, op2}, 32'd0);
        do_instr(1'b1, 1'b0, 1'b0, 8'h00, 0);
        chk("post_rst_udf", {31'd0, stack_underflow}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
